// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle instruction sequencer for the 16-register / ALU / flag-register
// datapath. Takes one 16-bit instruction over a valid/ready handshake, then
// walks IDLE -> DECODE -> EXEC -> WB -> IDLE. From DECODE through WB it drives
// operand buffer selects, ALU op/exop, immediate and carry-in. In WB it
// drives the register-file write strobe and the done/illegal pulses.
//
// Instruction format:
//   [15:12] op, [11:8] Rdest, [7:4] exop (RR only), [3:0] Rsrc, [7:0] imm8
//
// Parameters:
//   EXEC_CYCLES  cycles spent in EXEC for ALU settle (1..15)
//   IMM_SIGNED   1 = sign-extend imm8, 0 = zero-extend
//
// Optional feature macro: ALU_SEQ_BACKTOBACK_EN
//   defined   : instr_ready is also high in WB. An accept there goes straight
//               to DECODE, so throughput is 2+EXEC_CYCLES cycles/instruction.
//   undefined : instr_ready only in IDLE, so throughput is 3+EXEC_CYCLES.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   instr/instr_valid/instr_ready   instruction handshake
//   flags             flag register: [0]C [1]L [2]F [3]Z [4]N
//   reg_en            [4] write strobe, [3:0] destination register
//   buff_a_en         [4] drive A bus, [3:0] source register
//   buff_b_en         [4] drive B bus, [3:0] source register
//   reg_or_immed      1 = B operand from register, 0 = immediate
//   immediate         extended immediate
//   op, exop, cin     ALU controls
//   busy              instruction in flight (DECODE/EXEC/WB)
//   done, illegal     one-cycle pulses in WB
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter bit          IMM_SIGNED  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  flags,
  output logic [4:0]  reg_en,
  output logic [4:0]  buff_a_en,
  output logic [4:0]  buff_b_en,
  output logic        reg_or_immed,
  output logic [15:0] immediate,
  output logic [3:0]  op,
  output logic [3:0]  exop,
  output logic        cin,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [3:0] OP_RR      = 4'h0;
  localparam logic [3:0] OP_CARRY   = 4'h7;
  localparam logic [3:0] OP_CMP     = 4'hB;
  localparam logic [3:0] OP_ILLEGAL = 4'hF;
  localparam logic [3:0] EX_CARRY   = 4'h7;
  localparam logic [3:0] EX_CMP     = 4'hB;
  localparam logic [3:0] EXEC_LOAD  = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] ir_q;
  logic [3:0]  cnt_q;

  logic [4:0]  reg_en_q;
  logic [4:0]  buff_a_en_q;
  logic [4:0]  buff_b_en_q;
  logic        reg_or_immed_q;
  logic [15:0] immediate_q;
  logic [3:0]  op_q;
  logic [3:0]  exop_q;
  logic        cin_q;
  logic        done_q;
  logic        illegal_q;

  // -------------------------------------------------------------------------
  // Decode of the incoming word. The datapath controls are captured into
  // their output registers on the accept edge, so they are already valid in
  // DECODE and stay frozen until WB ends. Carry is sampled here as well.
  // -------------------------------------------------------------------------
  logic        in_rr;
  logic        in_ill;
  logic        in_carry;
  logic [4:0]  buff_a_en_d;
  logic [4:0]  buff_b_en_d;
  logic        reg_or_immed_d;
  logic [15:0] immediate_d;
  logic [3:0]  exop_d;
  logic        cin_d;

  always_comb begin
    in_rr    = (instr[15:12] == OP_RR);
    in_ill   = (instr[15:12] == OP_ILLEGAL);
    in_carry = (in_rr && instr[7:4] == EX_CARRY) || (instr[15:12] == OP_CARRY);

    buff_a_en_d    = 5'h00;
    buff_b_en_d    = 5'h00;
    reg_or_immed_d = 1'b1;
    immediate_d    = 16'h0000;
    exop_d         = 4'h0;
    cin_d          = 1'b0;

    if (!in_ill) begin
      buff_a_en_d = {1'b1, instr[11:8]};
      cin_d       = in_carry & flags[0];
      if (in_rr) begin
        buff_b_en_d = {1'b1, instr[3:0]};
        exop_d      = instr[7:4];
      end else begin
        reg_or_immed_d = 1'b0;
        immediate_d    = IMM_SIGNED ? {{8{instr[7]}}, instr[7:0]}
                                    : {8'h00, instr[7:0]};
      end
    end
  end

  // Write-back decision comes from the latched IR.
  logic       ir_ill;
  logic       ir_no_write;
  logic [4:0] reg_en_d;

  always_comb begin
    ir_ill      = (ir_q[15:12] == OP_ILLEGAL);
    ir_no_write = ((ir_q[15:12] == OP_RR) && (ir_q[7:4] == EX_CMP)) ||
                  (ir_q[15:12] == OP_CMP);
    reg_en_d    = (ir_ill || ir_no_write) ? 5'h00 : {1'b1, ir_q[11:8]};
  end

  // Rsrc is consumed at accept time and the upper flags are not used here.
  logic unused_bits;
  assign unused_bits = ^{ir_q[3:0], flags[4:1]};

  logic accept;

`ifdef ALU_SEQ_BACKTOBACK_EN
  // WB outputs come from registers, so a new word can be latched in WB
  // without disturbing the write strobe of the finishing instruction.
  assign instr_ready = (state_q == S_IDLE) || (state_q == S_WB);
`else
  assign instr_ready = (state_q == S_IDLE);
`endif

  assign accept = instr_valid & instr_ready;
  assign busy   = (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ir_q           <= 16'h0000;
      cnt_q          <= 4'h0;
      reg_en_q       <= 5'h00;
      buff_a_en_q    <= 5'h00;
      buff_b_en_q    <= 5'h00;
      reg_or_immed_q <= 1'b1;
      immediate_q    <= 16'h0000;
      op_q           <= 4'h0;
      exop_q         <= 4'h0;
      cin_q          <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      // WB-only pulses default low every cycle.
      reg_en_q  <= 5'h00;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;

      if (accept) begin
        state_q        <= S_DECODE;
        ir_q           <= instr;
        buff_a_en_q    <= buff_a_en_d;
        buff_b_en_q    <= buff_b_en_d;
        reg_or_immed_q <= reg_or_immed_d;
        immediate_q    <= immediate_d;
        op_q           <= instr[15:12];
        exop_q         <= exop_d;
        cin_q          <= cin_d;
      end else begin
        case (state_q)
          S_DECODE: begin
            cnt_q   <= EXEC_LOAD;
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            if (cnt_q == 4'h0) begin
              state_q   <= S_WB;
              reg_en_q  <= reg_en_d;
              done_q    <= 1'b1;
              illegal_q <= ir_ill;
            end else begin
              cnt_q <= cnt_q - 4'h1;
            end
          end
          S_WB: begin
            state_q        <= S_IDLE;
            ir_q           <= 16'h0000;
            buff_a_en_q    <= 5'h00;
            buff_b_en_q    <= 5'h00;
            reg_or_immed_q <= 1'b1;
            immediate_q    <= 16'h0000;
            op_q           <= 4'h0;
            exop_q         <= 4'h0;
            cin_q          <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign reg_en       = reg_en_q;
  assign buff_a_en    = buff_a_en_q;
  assign buff_b_en    = buff_b_en_q;
  assign reg_or_immed = reg_or_immed_q;
  assign immediate    = immediate_q;
  assign op           = op_q;
  assign exop         = exop_q;
  assign cin          = cin_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Scoreboard bench for alu_sequencer. The stimulus process pushes the
// expected behaviour of each accepted instruction into a queue. The monitor
// compares every busy cycle against the head entry and retires it on done.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int unsigned EXEC_CYCLES = 3;
  localparam bit          IMM_SIGNED  = 1'b1;
`ifdef ALU_SEQ_BACKTOBACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  flags;
  logic [4:0]  reg_en;
  logic [4:0]  buff_a_en;
  logic [4:0]  buff_b_en;
  logic        reg_or_immed;
  logic [15:0] immediate;
  logic [3:0]  op;
  logic [3:0]  exop;
  logic        cin;
  logic        busy;
  logic        done;
  logic        illegal;

  alu_sequencer #(
    .EXEC_CYCLES(EXEC_CYCLES),
    .IMM_SIGNED (IMM_SIGNED)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flags       (flags),
    .reg_en      (reg_en),
    .buff_a_en   (buff_a_en),
    .buff_b_en   (buff_b_en),
    .reg_or_immed(reg_or_immed),
    .immediate   (immediate),
    .op          (op),
    .exop        (exop),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [15:0] ins;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [3:0]  op;
    logic [3:0]  exop;
    logic        roi;
    logic [15:0] imm;
    logic        cin;
    logic [4:0]  reg_en;
    logic        ill;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   txn    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: expected controls straight from the instruction rules.
  function automatic exp_t model(input logic [15:0] ins, input logic [4:0] fl);
    exp_t e;
    int opn  = int'(ins[15:12]);
    int ex   = int'(ins[7:4]);
    int imm8 = int'(ins[7:0]);
    e.ins = ins; e.op = ins[15:12];
    e.a = 5'h00; e.b = 5'h00; e.exop = 4'h0; e.roi = 1'b1; e.imm = 16'h0000;
    e.cin = 1'b0; e.reg_en = 5'h00; e.ill = 1'b0; e.acc = 0;
    if (opn == 15) begin
      e.ill = 1'b1;
    end else begin
      e.a = {1'b1, ins[11:8]};
      if (opn == 0) begin
        e.exop = ins[7:4];
        e.b    = {1'b1, ins[3:0]};
      end else begin
        e.roi = 1'b0;
        if (IMM_SIGNED && imm8 >= 128) e.imm = 16'(imm8 - 256);
        else                           e.imm = 16'(imm8);
      end
      if ((opn == 0 && ex == 7) || opn == 7) e.cin = fl[0];
      if (!((opn == 0 && ex == 11) || opn == 11)) e.reg_en = {1'b1, ins[11:8]};
    end
    return e;
  endfunction

  // Monitor: compares outputs each cycle and retires transactions on done.
  exp_t m;
  always @(negedge clock) begin
    if (!reset) begin
      chk("instr_ready", 16'(instr_ready), busy ? 16'(B2B && done) : 16'd1);
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy_no_txn: busy=1, expected 0 with nothing in flight");
        end else begin
          m = exp_q[0];
          chk("buff_a_en", 16'(buff_a_en), 16'(m.a));
          chk("buff_b_en", 16'(buff_b_en), 16'(m.b));
          chk("op", 16'(op), 16'(m.op));
          chk("exop", 16'(exop), 16'(m.exop));
          chk("reg_or_immed", 16'(reg_or_immed), 16'(m.roi));
          chk("immediate", immediate, m.imm);
          chk("cin", 16'(cin), 16'(m.cin));
        end
      end else begin
        chk("idle_buff_a_en", 16'(buff_a_en), 16'd0);
        chk("idle_buff_b_en", 16'(buff_b_en), 16'd0);
        chk("idle_op_exop", 16'({op, exop}), 16'd0);
        chk("idle_reg_or_immed", 16'(reg_or_immed), 16'd1);
        chk("idle_immediate", immediate, 16'd0);
        chk("idle_cin", 16'(cin), 16'd0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_no_txn: done=1, expected 0 with nothing in flight");
        end else begin
          m = exp_q.pop_front();
          chk("wb_reg_en", 16'(reg_en), 16'(m.reg_en));
          chk("wb_illegal", 16'(illegal), 16'(m.ill));
          chk("latency", 16'(cyc - m.acc), 16'(1 + EXEC_CYCLES));
          txn++;
          $display("txn %0d: instr=%h reg_en=%h illegal=%b imm=%h cin=%b latency=%0d",
                   txn, m.ins, reg_en, illegal, immediate, cin, cyc - m.acc);
        end
      end else begin
        chk("reg_en_outside_wb", 16'(reg_en), 16'd0);
        chk("illegal_outside_wb", 16'(illegal), 16'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] ins, input logic [4:0] fl,
                      output int acc, output bit done_at_acc);
    int   waited = 0;
    exp_t e;
    instr = ins; flags = fl; instr_valid = 1'b1;
    while (!instr_ready && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    acc = -1; done_at_acc = 1'b0;
    if (!instr_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: instr_ready=0 after %0d cycles, expected 1", waited);
    end else begin
      e = model(ins, fl);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      acc = cyc + 1;
      done_at_acc = done;
    end
    @(negedge clock);
    instr_valid = 1'b0;
    flags = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d instructions outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_instr_ready", 16'(instr_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_reg_en", 16'(reg_en), 16'd0);
    chk("rst_buff_a_en", 16'(buff_a_en), 16'd0);
    chk("rst_buff_b_en", 16'(buff_b_en), 16'd0);
    chk("rst_op", 16'(op), 16'd0);
    chk("rst_exop", 16'(exop), 16'd0);
    chk("rst_reg_or_immed", 16'(reg_or_immed), 16'd1);
    chk("rst_immediate", immediate, 16'd0);
    chk("rst_cin", 16'(cin), 16'd0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0: w[15:12] = 4'h0;
      1: w[15:12] = 4'hF;
      2: begin w[15:12] = 4'h0; w[7:4] = 4'h7; end
      3: begin w[15:12] = 4'h0; w[7:4] = 4'hB; end
      4: w[15:12] = 4'h7;
      default: ;
    endcase
    return w;
  endfunction

  int acc_prev;
  int acc_now;
  bit d_at;

  initial begin
    reset = 1'b1; instr = 16'h0000; instr_valid = 1'b0; flags = 5'h00;
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clock);

    // Directed vectors, each drained before the next.
    send(16'h0152, 5'h1E, acc_now, d_at); drain();
    send(16'h53F6, 5'h1F, acc_now, d_at); drain();
    send(16'h04B5, 5'h00, acc_now, d_at); drain();
    send(16'h0712, 5'h01, acc_now, d_at); drain();
    send(16'h0712, 5'h00, acc_now, d_at); drain();
    send(16'h7A80, 5'h01, acc_now, d_at); drain();
    send(16'hF000, 5'h01, acc_now, d_at); drain();
    send(16'hB123, 5'h00, acc_now, d_at); drain();

    // Words offered while busy must be ignored.
    send(16'h2345, 5'h00, acc_now, d_at);
    instr_valid = 1'b1;
    for (int i = 0; i < int'(EXEC_CYCLES); i++) begin
      instr = 16'($urandom);
      @(negedge clock);
    end
    instr_valid = 1'b0;
    drain();

    // Valid held high: accept spacing and overlap with done.
    send(16'h0152, 5'h00, acc_prev, d_at);
    for (int i = 0; i < 3; i++) begin
      send(rand_instr(), 5'($urandom), acc_now, d_at);
      chk("accept_spacing", 16'(acc_now - acc_prev),
          16'(B2B ? 2 + EXEC_CYCLES : 3 + EXEC_CYCLES));
      chk("done_at_accept", 16'(d_at), 16'(B2B));
      acc_prev = acc_now;
    end
    drain();

    // Reset while in EXEC: instruction discarded, then normal operation.
    send(16'h0123, 5'h01, acc_now, d_at);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_reset_vals();
    reset = 1'b0;
    repeat (2 + EXEC_CYCLES) @(negedge clock);
    send(16'h0921, 5'h00, acc_now, d_at); drain();

    // Randomized traffic with random gaps.
    for (int i = 0; i < 40; i++) begin
      send(rand_instr(), 5'($urandom), acc_now, d_at);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
